// File: rtl/dht11_pkg.sv
// dht11_pkg: DHT11 responder states and default protocol timing in microseconds
package dht11_pkg;
    typedef enum logic [2:0] {
        IDLE, START, DELAY, RSP_LO, RSP_HI, BIT_LO, BIT_HI, END_LO
    } dht11_state_t;
    localparam int DEF_CCL_SZ         = 50;
    localparam int DEF_BYTE_SZ        = 8;
    localparam int DEF_DATA_SZ        = 40;
    localparam int DEF_VALUE_SZ       = 16;
    localparam int DEF_T_START_MIN_US = 18000;
    localparam int DEF_T_WAIT_US      = 30;
    localparam int DEF_T_RSP_LO_US    = 80;
    localparam int DEF_T_RSP_HI_US    = 80;
    localparam int DEF_T_BIT_LO_US    = 50;
    localparam int DEF_T_ZERO_HI_US   = 26;
    localparam int DEF_T_ONE_HI_US    = 70;
endpackage

// File: rtl/dht11_emu_us_tick.sv
// us_tick: CCL_SZ-cycle prescaler emitting a one-cycle tick per microsecond
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous restart of the microsecond period
//   tick : high for the last cycle of every microsecond
module us_tick #(
    parameter int CCL_SZ = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CCL_SZ + 1);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CCL_SZ - 1);
    always_ff @(posedge clk)
        if (rst || clr || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
endmodule

// File: rtl/dht11_emu.sv
// dht11_emu: DHT11 sensor emulator driving response preamble and 40-bit frame open-drain
//   CLK, RST       : clock, synchronous active-high reset
//   I_HUM, I_TEMP  : {integer, decimal} values latched at start accept
//   I_DHT11        : asynchronous data line sample
//   O_DHT11_OE     : 1 pulls the line low, 0 releases
//   O_BUSY         : high from start accept through end of frame
//   O_DONE, O_ERR  : one-cycle pulses on frame complete / too-short host start
//   I_CORRUPT      : only with DHT11_EMU_CHK_ERR_EN; inverts the sent checksum
module dht11_emu
    import dht11_pkg::*;
#(
    parameter int CCL_SZ         = DEF_CCL_SZ,
    parameter int BYTE_SZ        = DEF_BYTE_SZ,
    parameter int DATA_SZ        = DEF_DATA_SZ,
    parameter int VALUE_SZ       = DEF_VALUE_SZ,
    parameter int T_START_MIN_US = DEF_T_START_MIN_US,
    parameter int T_WAIT_US      = DEF_T_WAIT_US,
    parameter int T_RSP_LO_US    = DEF_T_RSP_LO_US,
    parameter int T_RSP_HI_US    = DEF_T_RSP_HI_US,
    parameter int T_BIT_LO_US    = DEF_T_BIT_LO_US,
    parameter int T_ZERO_HI_US   = DEF_T_ZERO_HI_US,
    parameter int T_ONE_HI_US    = DEF_T_ONE_HI_US
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [VALUE_SZ-1:0] I_HUM,
    input  logic [VALUE_SZ-1:0] I_TEMP,
    input  logic                I_DHT11,
    output logic                O_DHT11_OE,
    output logic                O_BUSY,
    output logic                O_DONE,
    output logic                O_ERR
`ifdef DHT11_EMU_CHK_ERR_EN
    ,
    input  logic                I_CORRUPT
`endif
);
    localparam int IW = $clog2(DATA_SZ);
    dht11_state_t       state, next;
    logic [2:0]         sync;
    logic               rise, fall, tick, clr, done_t, start_ok, latch;
    logic [15:0]        us, dur;
    logic [IW-1:0]      idx;
    logic [DATA_SZ-1:0] frame;
    logic [BYTE_SZ-1:0] chk, chk_tx;

    // sync[1:0] is the synchronizer, sync[2] the edge register
    assign rise     = sync[1] & ~sync[2];
    assign fall     = ~sync[1] & sync[2];
    // restarting the timebase on every state change makes an N us state exactly N*CCL_SZ cycles
    assign clr      = next != state;
    assign start_ok = us >= 16'(T_START_MIN_US);
    assign latch    = state == START && rise && start_ok;
    assign done_t   = tick && us == dur - 16'd1;
    assign chk      = I_HUM[2*BYTE_SZ-1:BYTE_SZ] + I_HUM[BYTE_SZ-1:0]
                    + I_TEMP[2*BYTE_SZ-1:BYTE_SZ] + I_TEMP[BYTE_SZ-1:0];
`ifdef DHT11_EMU_CHK_ERR_EN
    assign chk_tx   = chk ^ {BYTE_SZ{I_CORRUPT}};
`else
    assign chk_tx   = chk;
`endif
    assign dur = state == DELAY  ? 16'(T_WAIT_US)
               : state == RSP_LO ? 16'(T_RSP_LO_US)
               : state == RSP_HI ? 16'(T_RSP_HI_US)
               : state == BIT_HI ? (frame[idx] ? 16'(T_ONE_HI_US) : 16'(T_ZERO_HI_US))
               : 16'(T_BIT_LO_US);

    us_tick #(.CCL_SZ(CCL_SZ)) u_tick (.clk(CLK), .rst(RST), .clr(clr), .tick(tick));

    always_ff @(posedge CLK) begin
        sync <= RST ? '1 : {sync[1:0], I_DHT11};
        // the START count saturates so an arbitrarily long hold stays a valid start
        if (RST || clr) us <= '0;
        else if (tick && !(state == START && start_ok)) us <= us + 16'd1;
        if (RST) begin
            frame <= '0;
            idx   <= '0;
        end else if (latch) begin
            frame <= {I_HUM, I_TEMP, chk_tx};
            idx   <= IW'(DATA_SZ - 1);
        end else if (state == BIT_HI && done_t && idx != '0) begin
            idx   <= idx - 1'b1;
        end
    end

    always_ff @(posedge CLK)
        state <= RST ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (fall) next = START;
            START:   if (rise) next = start_ok ? DELAY : IDLE;
            DELAY:   if (done_t) next = RSP_LO;
            RSP_LO:  if (done_t) next = RSP_HI;
            RSP_HI:  if (done_t) next = BIT_LO;
            BIT_LO:  if (done_t) next = BIT_HI;
            BIT_HI:  if (done_t) next = idx == '0 ? END_LO : BIT_LO;
            END_LO:  if (done_t) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        O_DHT11_OE = state inside {RSP_LO, BIT_LO, END_LO};
        O_BUSY     = !(state inside {IDLE, START});
        O_DONE     = state == END_LO && done_t;
        O_ERR      = state == START && rise && !start_ok;
    end
endmodule

// File: tb/tb_dht11_emu.sv
// tb_dht11_emu: directed loopback bench decoding the emulator waveform against expected frames
module tb_dht11_emu;
    localparam int CCL  = 2;
    localparam int TMIN = 20;
    typedef struct {
        logic [39:0] f;
        bit          bad;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        host_pull = 1'b0;
    logic [15:0] hum = '0;
    logic [15:0] temp = '0;
    logic        line, oe, busy, done, err;
    int          total = 0, passed = 0, failed = 0, done_cnt = 0, err_cnt = 0;
    exp_t        sb[$];
`ifdef DHT11_EMU_CHK_ERR_EN
    logic        corrupt = 1'b0;
`endif

    assign line = !(oe || host_pull);
    always #10 CLK = ~CLK;

    dht11_emu #(.CCL_SZ(CCL), .T_START_MIN_US(TMIN)) dut (
        .CLK(CLK), .RST(RST), .I_HUM(hum), .I_TEMP(temp), .I_DHT11(line),
        .O_DHT11_OE(oe), .O_BUSY(busy), .O_DONE(done), .O_ERR(err)
`ifdef DHT11_EMU_CHK_ERR_EN
        , .I_CORRUPT(corrupt)
`endif
    );

    always @(negedge CLK) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] h, input logic [15:0] t, input bit bad);
        logic [7:0] c;
        exp_t e;
        c = h[15:8] + h[7:0] + t[15:8] + t[7:0];
        e.f = {h, t, bad ? ~c : c};
        e.bad = bad;
        sb.push_back(e);
        hum = h;
        temp = t;
    endtask

    task automatic host_start(input int us);
        @(negedge CLK);
        host_pull = 1'b1;
        repeat (us * CCL) @(negedge CLK);
        host_pull = 1'b0;
    endtask

    // cycles until OE leaves val, bounded
    task automatic measure(input logic val, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (oe === val && n < 10000);
    endtask

    task automatic run_frame(input int hold_us, input int abort_at, input bit scramble);
        exp_t e;
        logic [39:0] got;
        logic [7:0] s;
        int n, bad, d0;
        e = sb.pop_front();
        d0 = done_cnt;
        host_start(hold_us);
        measure(1'b0, n); check("latency", n, 3 + 30 * CCL);
        if (scramble) begin
            hum = 16'h0000;
            temp = 16'hFFFF;
        end
        measure(1'b1, n); check("rsp_lo", n, 80 * CCL);
        measure(1'b0, n); check("rsp_hi", n, 80 * CCL);
        got = '0;
        bad = 0;
        for (int i = 39; i >= 0; i--) begin
            measure(1'b1, n);
            if (n != 50 * CCL) bad++;
            if (i == abort_at) begin
                repeat (10) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                check("rst_release", {oe, busy}, 2'b00);
                RST = 1'b0;
                check("rst_bit_lo", bad, 0);
                return;
            end
            measure(1'b0, n);
            got[i] = n > 48 * CCL;
            if (n != (e.f[i] ? 70 * CCL : 26 * CCL)) bad++;
        end
        check("frame", got, e.f);
        check("bit_times", bad, 0);
        s = got[39:32] + got[31:24] + got[23:16] + got[15:8];
        check("chk_ok", s == got[7:0], !e.bad);
        measure(1'b1, n); check("end_lo", n, 50 * CCL);
        check("done_pulse", done_cnt - d0, 1);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int e0;
        logic oe_any, busy_any;
        repeat (5) @(negedge CLK);
        check("reset_outs", {oe, busy, done, err}, 4'b0000);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("post_reset_outs", {oe, busy, done, err}, 4'b0000);

        push(16'h3700, 16'h1905, 1'b0);
        run_frame(25, -1, 1'b0);

        push(16'hFFFF, 16'hFF02, 1'b0);
        run_frame(TMIN + 1, -1, 1'b0);

        e0 = err_cnt;
        host_start(TMIN - 1);
        oe_any = 1'b0;
        busy_any = 1'b0;
        repeat (200 * CCL) begin
            @(negedge CLK);
            oe_any |= oe;
            busy_any |= busy;
        end
        check("short_err", err_cnt - e0, 1);
        check("short_oe", oe_any, 1'b0);
        check("short_busy", busy_any, 1'b0);

        push(16'h1234, 16'h5678, 1'b0);
        run_frame(200, -1, 1'b1);

        push(16'h3700, 16'h1905, 1'b0);
        run_frame(25, 12, 1'b0);
        repeat (20) @(negedge CLK);
        push(16'h3700, 16'h1905, 1'b0);
        run_frame(25, -1, 1'b0);

`ifdef DHT11_EMU_CHK_ERR_EN
        corrupt = 1'b1;
        push(16'h3700, 16'h1905, 1'b1);
        run_frame(25, -1, 1'b0);
        corrupt = 1'b0;
`endif

        check("err_total", err_cnt, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
